// File: rtl/izhikevich_array.sv
// Time-multiplexed Izhikevich neuron engine: N neurons share one 3-stage saturating fixed-point update pipe.
// Latency: spike pulse 2 cycles after a current beat is accepted; done 3 cycles after the last beat.
// Backpressure: i_ready_o is high only in RUN; an i_valid_i bubble holds the neuron counter, the pipe never stalls.
module izhikevich_array #(
   parameter int N_NEURONS = 16,
   parameter int W         = 16,
   parameter int FRAC      = 8,
   parameter int IDX_W     = $clog2(N_NEURONS),
   parameter int V_TH      = 30 * 256,
   parameter int RST_V     = -65 * 256,
   parameter int RST_U     = -13 * 256
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [W-1:0]     a_i,
   input  logic [W-1:0]     b_i,
   input  logic [W-1:0]     c_i,
   input  logic [W-1:0]     d_i,
   input  logic             step_start_i,
   input  logic             i_valid_i,
   input  logic [W-1:0]     i_data_i,
   output logic             i_ready_o,
   input  logic             st_we_i,
   input  logic [IDX_W-1:0] st_addr_i,
   input  logic [W-1:0]     st_v_i,
   input  logic [W-1:0]     st_u_i,
   output logic             spk_valid_o,
   output logic [IDX_W-1:0] spk_idx_o,
   output logic             busy_o,
   output logic             done_o
);

   // Internal arithmetic width: room for a full WxW product plus headroom for the sums.
   localparam int XW = 2 * W + 8;
   typedef logic signed [XW-1:0] wide_t;

   localparam wide_t K_QUAD  = wide_t'(10);                 // 0.04 ~= 10/256
   localparam wide_t K_LIN   = wide_t'(5);
   localparam wide_t K_OFS   = wide_t'(140) <<< FRAC;
   localparam wide_t V_TH_X  = wide_t'(V_TH);
   localparam wide_t SAT_MAX = (wide_t'(1) <<< (W - 1)) - wide_t'(1);
   localparam wide_t SAT_MIN = -(wide_t'(1) <<< (W - 1));
   localparam logic [IDX_W-1:0] LAST = IDX_W'(N_NEURONS - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   // Clamp a wide intermediate into the signed W-bit range.
   function automatic logic signed [W-1:0] sat(input wide_t x);
      logic signed [W-1:0] r;
      if (x > SAT_MAX) begin
         r = SAT_MAX[W-1:0];
      end else if (x < SAT_MIN) begin
         r = SAT_MIN[W-1:0];
      end else begin
         r = x[W-1:0];
      end
      return r;
   endfunction

   state_t state_q, state_d;
   logic [IDX_W-1:0] k_q, k_d;

   logic signed [W-1:0] v_q [N_NEURONS];
   logic signed [W-1:0] u_q [N_NEURONS];

   logic signed [W-1:0] a_q, b_q, c_q, d_q;

   logic accept;
   logic host_we;

   // Stage 1 registers: operands read from the state file
   logic             s1_vld_q;
   logic [IDX_W-1:0] s1_idx_q;
   logic signed [W-1:0] s1_v_q, s1_u_q, s1_i_q;

   // Stage 2 registers: products ready for the final update
   logic             s2_vld_q;
   logic [IDX_W-1:0] s2_idx_q;
   logic signed [W-1:0] s2_v_q, s2_u_q, s2_i_q;
   wide_t            s2_quad_q, s2_bv_q;

   wide_t s1_v_x, s1_vv, s1_quad, s1_bv;
   wide_t v2x, u2x, dv, vn, du, un, ud;
   logic  spike;
   logic signed [W-1:0] v_wb, u_wb;

   assign accept  = i_ready_o & i_valid_i;
   assign host_we = st_we_i & (state_q == IDLE);

   // FSM state and neuron issue counter registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         k_q     <= '0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
      end
   end

   // FSM next-state, counter advance and control outputs.
   always_comb begin
      state_d   = state_q;
      k_d       = k_q;
      busy_o    = 1'b0;
      done_o    = 1'b0;
      i_ready_o = 1'b0;
      case (state_q)
         IDLE: begin
            if (step_start_i) begin
               state_d = RUN;
               k_d     = '0;
            end
         end
         RUN: begin
            busy_o    = 1'b1;
            i_ready_o = 1'b1;
            if (i_valid_i) begin
               if (k_q == LAST) begin
                  state_d = DRAIN;
                  k_d     = '0;
               end else begin
                  k_d = k_q + IDX_W'(1);
               end
            end
         end
         DRAIN: begin
            busy_o = 1'b1;
            if (!s1_vld_q && !s2_vld_q) begin
               done_o  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Model parameters are frozen for the whole step at the accepted step_start.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         a_q <= '0;
         b_q <= '0;
         c_q <= '0;
         d_q <= '0;
      end else if ((state_q == IDLE) && step_start_i) begin
         a_q <= $signed(a_i);
         b_q <= $signed(b_i);
         c_q <= $signed(c_i);
         d_q <= $signed(d_i);
      end
   end

   // State file: host writes only while idle, pipe write-back only while busy, so they never collide.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int n = 0; n < N_NEURONS; n++) begin
            v_q[n] <= W'(RST_V);
            u_q[n] <= W'(RST_U);
         end
      end else if (host_we) begin
         v_q[st_addr_i] <= $signed(st_v_i);
         u_q[st_addr_i] <= $signed(st_u_i);
      end else if (s2_vld_q) begin
         v_q[s2_idx_q] <= v_wb;
         u_q[s2_idx_q] <= u_wb;
      end
   end

   // S0: read v,u of the issued neuron together with its input current.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         s1_vld_q <= 1'b0;
         s1_idx_q <= '0;
         s1_v_q   <= '0;
         s1_u_q   <= '0;
         s1_i_q   <= '0;
      end else begin
         s1_vld_q <= accept;
         if (accept) begin
            s1_idx_q <= k_q;
            s1_v_q   <= v_q[k_q];
            s1_u_q   <= u_q[k_q];
            s1_i_q   <= $signed(i_data_i);
         end
      end
   end

   // S1 products: 0.04*v^2 and b*v, each rescaled by truncating FRAC bits.
   assign s1_v_x  = wide_t'(s1_v_q);
   assign s1_vv   = (s1_v_x * s1_v_x) >>> FRAC;
   assign s1_quad = (s1_vv * K_QUAD) >>> FRAC;
   assign s1_bv   = (wide_t'(b_q) * s1_v_x) >>> FRAC;

   // S1 -> S2 pipeline register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         s2_vld_q  <= 1'b0;
         s2_idx_q  <= '0;
         s2_v_q    <= '0;
         s2_u_q    <= '0;
         s2_i_q    <= '0;
         s2_quad_q <= '0;
         s2_bv_q   <= '0;
      end else begin
         s2_vld_q <= s1_vld_q;
         if (s1_vld_q) begin
            s2_idx_q  <= s1_idx_q;
            s2_v_q    <= s1_v_q;
            s2_u_q    <= s1_u_q;
            s2_i_q    <= s1_i_q;
            s2_quad_q <= s1_quad;
            s2_bv_q   <= s1_bv;
         end
      end
   end

   // S2: Euler update; threshold uses the unsaturated vn so large overshoots still spike.
   assign v2x   = wide_t'(s2_v_q);
   assign u2x   = wide_t'(s2_u_q);
   assign dv    = s2_quad_q + (K_LIN * v2x) + K_OFS - u2x + wide_t'(s2_i_q);
   assign vn    = v2x + dv;
   assign du    = (wide_t'(a_q) * (s2_bv_q - u2x)) >>> FRAC;
   assign un    = u2x + du;
   assign ud    = u2x + wide_t'(d_q);
   assign spike = s2_vld_q & (vn >= V_TH_X);
   assign v_wb  = spike ? c_q : sat(vn);
   assign u_wb  = spike ? sat(ud) : sat(un);

   assign spk_valid_o = spike;
   assign spk_idx_o   = spike ? s2_idx_q : '0;

endmodule

// File: tb/tb_izhikevich_array.sv
// Directed bench for izhikevich_array with an arithmetic reference model and per-cycle spike/done comparison.
// Latency: expects spikes 2 cycles and done 3 cycles after the relevant accepted beat.
// Backpressure: drives i_valid bubbles to exercise counter hold; never stalls on the DUT beyond a fixed budget.
module tb_izhikevich_array;

   localparam int N     = 16;
   localparam int W     = 16;
   localparam int IDX_W = 4;
   localparam longint ONE   = 256;
   localparam longint RSTV  = -16640;
   localparam longint RSTU  = -3328;
   localparam longint VTH   = 7680;
   localparam longint P_A   = 5;
   localparam longint P_B   = 51;
   localparam longint P_C   = -16640;
   localparam longint P_D   = 2048;

   logic             clk = 1'b0;
   logic             rst;
   logic [W-1:0]     a_i, b_i, c_i, d_i;
   logic             step_start_i;
   logic             i_valid_i;
   logic [W-1:0]     i_data_i;
   logic             i_ready_o;
   logic             st_we_i;
   logic [IDX_W-1:0] st_addr_i;
   logic [W-1:0]     st_v_i, st_u_i;
   logic             spk_valid_o;
   logic [IDX_W-1:0] spk_idx_o;
   logic             busy_o;
   logic             done_o;

   always #5 clk = ~clk;

   izhikevich_array dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .a_i          (a_i),
      .b_i          (b_i),
      .c_i          (c_i),
      .d_i          (d_i),
      .step_start_i (step_start_i),
      .i_valid_i    (i_valid_i),
      .i_data_i     (i_data_i),
      .i_ready_o    (i_ready_o),
      .st_we_i      (st_we_i),
      .st_addr_i    (st_addr_i),
      .st_v_i       (st_v_i),
      .st_u_i       (st_u_i),
      .spk_valid_o  (spk_valid_o),
      .spk_idx_o    (spk_idx_o),
      .busy_o       (busy_o),
      .done_o       (done_o)
   );

   int checks   = 0;
   int failures = 0;

   // Reference model state
   longint mv [N];
   longint mu [N];
   longint ma, mb, mc, md;
   longint cur [N];

   typedef struct {
      int due;
      int idx;
   } spk_t;
   spk_t sq [$];

   int cyc       = 0;
   int mk        = 0;
   int done_due  = -1;
   int done_cnt  = 0;
   int done_cyc  = 0;
   int first_cyc = 0;
   int spk_cnt   = 0;
   int last_spk  = -1;

   task automatic chk(input string nm, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic longint msat(input longint x);
      if (x > 32767) return 32767;
      if (x < -32768) return -32768;
      return x;
   endfunction

   // Fixed-point product in Q8.8: full product, then drop FRAC bits (floor).
   function automatic longint qmul(input longint x, input longint y);
      return (x * y) >>> 8;
   endfunction

   // One Euler step of neuron n with current i, straight from the model equations.
   function automatic void model_update(input int n, input longint i, output bit spk);
      longint v, u, dv, vn;
      v  = mv[n];
      u  = mu[n];
      dv = qmul(qmul(v, v), 10) + 5 * v + 140 * ONE - u + i;
      vn = v + dv;
      spk = (vn >= VTH);
      if (spk) begin
         mv[n] = mc;
         mu[n] = msat(u + md);
      end else begin
         mv[n] = msat(vn);
         mu[n] = msat(u + qmul(ma, qmul(mb, v) - u));
      end
   endfunction

   // Per-cycle comparison of spike stream and done pulse against the model.
   always @(negedge clk) begin
      bit ev;
      bit spkb;
      if (rst) begin
         for (int n = 0; n < N; n++) begin
            mv[n] = RSTV;
            mu[n] = RSTU;
         end
         sq.delete();
         done_due = -1;
         mk = 0;
      end else begin
         ev = (sq.size() > 0) && (sq[0].due == cyc);
         chk("spk_valid", longint'(spk_valid_o), longint'(ev));
         if (spk_valid_o) begin
            spk_cnt++;
            last_spk = int'(spk_idx_o);
         end
         if (ev) begin
            chk("spk_idx", longint'(spk_idx_o), longint'(sq[0].idx));
            void'(sq.pop_front());
         end
         chk("done", longint'(done_o), longint'(cyc == done_due));
         if (done_o) begin
            done_cnt++;
            done_cyc = cyc;
         end
         if (i_valid_i && i_ready_o) begin
            if (mk == 0) first_cyc = cyc;
            model_update(mk, longint'($signed(i_data_i)), spkb);
            if (spkb) sq.push_back('{cyc + 2, mk});
            if (mk == N - 1) begin
               done_due = cyc + 3;
               mk = 0;
            end else begin
               mk++;
            end
         end
      end
      cyc++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_state(input string tag);
      for (int n = 0; n < N; n++) begin
         chk({tag, "_v"}, longint'(dut.v_q[n]), mv[n]);
         chk({tag, "_u"}, longint'(dut.u_q[n]), mu[n]);
      end
   endtask

   task automatic host_write(input int n, input longint v, input longint u);
      st_we_i   = 1'b1;
      st_addr_i = IDX_W'(n);
      st_v_i    = W'(v);
      st_u_i    = W'(u);
      tick();
      st_we_i   = 1'b0;
      mv[n] = v;
      mu[n] = u;
   endtask

   task automatic set_params();
      a_i = W'(P_A);
      b_i = W'(P_B);
      c_i = W'(P_C);
      d_i = W'(P_D);
      ma = P_A;
      mb = P_B;
      mc = P_C;
      md = P_D;
   endtask

   // One full step: optional simultaneous host write, optional stall, optional busy-time pokes.
   task automatic run_step(input int stall_at, input int stall_len, input int wr_n,
                           input longint wr_v, input longint wr_u, input bit poke);
      set_params();
      step_start_i = 1'b1;
      if (wr_n >= 0) begin
         st_we_i   = 1'b1;
         st_addr_i = IDX_W'(wr_n);
         st_v_i    = W'(wr_v);
         st_u_i    = W'(wr_u);
         mv[wr_n]  = wr_v;
         mu[wr_n]  = wr_u;
      end
      tick();
      step_start_i = 1'b0;
      st_we_i      = 1'b0;
      // Scramble parameters: the step must keep using the latched ones.
      a_i = 16'h7fff;
      b_i = 16'h0000;
      c_i = 16'h1111;
      d_i = 16'h7fff;
      for (int n = 0; n < N; n++) begin
         i_valid_i = 1'b1;
         i_data_i  = W'(cur[n]);
         if (poke && n == 4) begin
            step_start_i = 1'b1;
            st_we_i      = 1'b1;
            st_addr_i    = 4'd9;
            st_v_i       = 16'd5000;
            st_u_i       = 16'd77;
         end
         tick();
         step_start_i = 1'b0;
         st_we_i      = 1'b0;
         if (n == stall_at) begin
            i_valid_i = 1'b0;
            i_data_i  = 16'h1234;
            repeat (stall_len) tick();
         end
      end
      i_valid_i = 1'b0;
      i_data_i  = '0;
      repeat (6) tick();
      chk("busy_after_step", longint'(busy_o), 0);
   endtask

   initial begin
      int s0, d0;
      rst          = 1'b1;
      step_start_i = 1'b0;
      i_valid_i    = 1'b0;
      i_data_i     = '0;
      st_we_i      = 1'b0;
      st_addr_i    = '0;
      st_v_i       = '0;
      st_u_i       = '0;
      a_i = '0; b_i = '0; c_i = '0; d_i = '0;
      for (int n = 0; n < N; n++) cur[n] = 0;
      repeat (2) tick();

      // Reset state
      chk("rst_busy", longint'(busy_o), 0);
      chk("rst_done", longint'(done_o), 0);
      chk("rst_i_ready", longint'(i_ready_o), 0);
      chk("rst_spk_valid", longint'(spk_valid_o), 0);
      chk("rst_spk_idx", longint'(spk_idx_o), 0);
      chk("rst_v0", longint'(dut.v_q[0]), -16640);
      chk("rst_u15", longint'(dut.u_q[15]), -3328);
      rst = 1'b0;
      tick();

      // 1: reset in the middle of a step, right after neuron 7 is issued
      set_params();
      step_start_i = 1'b1;
      tick();
      step_start_i = 1'b0;
      for (int n = 0; n <= 7; n++) begin
         i_valid_i = 1'b1;
         i_data_i  = W'(n * 1000);
         tick();
      end
      chk("mid_busy_before_rst", longint'(busy_o), 1);
      i_valid_i = 1'b0;
      rst = 1'b1;
      tick();
      chk("mid_rst_busy", longint'(busy_o), 0);
      rst = 1'b0;
      tick();
      chk("mid_rst_busy_after", longint'(busy_o), 0);
      chk("mid_rst_i_ready", longint'(i_ready_o), 0);
      for (int n = 0; n < N; n++) begin
         chk("mid_rst_v", longint'(dut.v_q[n]), -16640);
         chk("mid_rst_u", longint'(dut.u_q[n]), -3328);
      end

      // 2: all currents zero from the reset state
      for (int n = 0; n < N; n++) cur[n] = 0;
      s0 = spk_cnt; d0 = done_cnt;
      run_step(-1, 0, -1, 0, 0, 1'b0);
      chk("t2_spikes", longint'(spk_cnt - s0), 0);
      chk("t2_done_cnt", longint'(done_cnt - d0), 1);
      chk("t2_done_latency", longint'(done_cyc - first_cyc), N + 2);
      for (int n = 0; n < N; n++) chk("t2_v_lit", longint'(dut.v_q[n]), -18422);
      chk("t2_u0_lit", longint'(dut.u_q[0]), -3328);
      check_state("t2");

      // 3: neuron 3 preloaded just below threshold spikes
      host_write(3, 7424, 0);
      s0 = spk_cnt;
      run_step(-1, 0, -1, 0, 0, 1'b0);
      chk("t3_spikes", longint'(spk_cnt - s0), 1);
      chk("t3_spk_idx", longint'(last_spk), 3);
      chk("t3_v3_lit", longint'(dut.v_q[3]), -16640);
      chk("t3_u3_lit", longint'(dut.u_q[3]), 2048);
      check_state("t3");

      // 4: 3-cycle bubble after neuron 5 with mixed currents
      for (int n = 0; n < N; n++) cur[n] = longint'(n * 200 - 1500);
      d0 = done_cnt;
      run_step(5, 3, -1, 0, 0, 1'b0);
      chk("t4_done_cnt", longint'(done_cnt - d0), 1);
      chk("t4_done_latency", longint'(done_cyc - first_cyc), N + 2 + 3);
      check_state("t4");

      // 5: strongly negative v and current saturate without wrapping
      for (int n = 0; n < N; n++) cur[n] = 0;
      cur[0] = -32768;
      host_write(0, -25600, 0);
      run_step(-1, 0, -1, 0, 0, 1'b0);
      chk("t5_v0_lit", longint'(dut.v_q[0]), -32768);
      chk("t5_u0_lit", longint'(dut.u_q[0]), -100);
      check_state("t5");

      // 6: write coincident with step_start is used; pokes while busy are dropped
      for (int n = 0; n < N; n++) cur[n] = 0;
      s0 = spk_cnt; d0 = done_cnt;
      run_step(-1, 0, 3, 7424, 0, 1'b1);
      chk("t6_spikes", longint'(spk_cnt - s0), 1);
      chk("t6_spk_idx", longint'(last_spk), 3);
      chk("t6_done_cnt", longint'(done_cnt - d0), 1);
      chk("t6_v3_lit", longint'(dut.v_q[3]), -16640);
      chk("t6_u3_lit", longint'(dut.u_q[3]), 2048);
      check_state("t6");
      repeat (4) tick();
      chk("t6_idle_busy", longint'(busy_o), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog timeout actual=running required=finished");
      $fatal(1, "watchdog");
   end

endmodule
